// File: rtl/divider_pkg.sv
// Shared definitions for the EX-stage divider: bus widths, funct codes,
// FSM state encodings and a small conditional-negate helper.
package divider_pkg;

  localparam int DATA_BUS        = 32;
  localparam int DOUBLE_DATA_BUS = 64;
  localparam int FUNCT_BUS       = 6;

  localparam logic [FUNCT_BUS-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_BUS-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [4:0] DIV_ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [DATA_BUS-1:0] neg_if(input logic [DATA_BUS-1:0] value,
                                                 input logic              negate);
    return negate ? (~value + 32'd1) : value;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One radix-2 restoring iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module divider_step
  import divider_pkg::*;
(
  input  logic [DATA_BUS:0]   rem,
  input  logic                dividend_bit,
  input  logic [DATA_BUS-1:0] divisor,
  output logic [DATA_BUS:0]   rem_next,
  output logic                q_bit
);

  logic [DATA_BUS+1:0] shifted;
  logic [DATA_BUS+1:0] diff;

  // Partial remainder stays below the divisor, so the shifted value fits in
  // 33 bits; one extra bit carries the borrow of the trial subtraction.
  always_comb begin
    shifted  = {rem, dividend_bit};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[DATA_BUS+1];
    rem_next = q_bit ? diff[DATA_BUS:0] : shifted[DATA_BUS:0];
  end

endmodule

// File: rtl/divider.sv
// Multi-cycle signed/unsigned 32-bit restoring divider producing
// {remainder, quotient} in HI/LO packing; one quotient bit per clock.
module divider
  import divider_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       annul,
  input  logic [FUNCT_BUS-1:0]       funct,
  input  logic [DATA_BUS-1:0]        operand_1,
  input  logic [DATA_BUS-1:0]        operand_2,
  output logic                       busy,
  output logic                       done,
  output logic [DOUBLE_DATA_BUS-1:0] result_div
);

  div_state_e                 state;
  logic [4:0]                 count;
  logic [DATA_BUS:0]          rem;
  logic [DATA_BUS-1:0]        dividend;
  logic [DATA_BUS-1:0]        divisor;
  logic                       dividend_neg;
  logic                       quotient_neg;
  logic [DOUBLE_DATA_BUS-1:0] result;

  logic [DATA_BUS:0]          step_rem;
  logic                       step_q;
  logic [DATA_BUS-1:0]        final_quot;
  logic                       is_signed;
  logic                       accept;

  divider_step u_step (
    .rem          (rem),
    .dividend_bit (dividend[DATA_BUS-1]),
    .divisor      (divisor),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  // Request decode and the quotient as it will stand after this iteration.
  always_comb begin
    is_signed  = (funct == FUNCT_DIV);
    accept     = start && !annul && ((funct == FUNCT_DIV) || (funct == FUNCT_DIVU));
    final_quot = {dividend[DATA_BUS-2:0], step_q};
  end

  // Divider FSM; the dividend register shifts out MSB-first while the
  // quotient bits shift into its LSB end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DIV_IDLE;
      count        <= 5'd0;
      rem          <= 33'd0;
      dividend     <= 32'd0;
      divisor      <= 32'd0;
      dividend_neg <= 1'b0;
      quotient_neg <= 1'b0;
      result       <= 64'd0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            dividend     <= neg_if(operand_1, is_signed && operand_1[DATA_BUS-1]);
            divisor      <= neg_if(operand_2, is_signed && operand_2[DATA_BUS-1]);
            dividend_neg <= is_signed && operand_1[DATA_BUS-1];
            quotient_neg <= is_signed && (operand_1[DATA_BUS-1] ^ operand_2[DATA_BUS-1]);
            rem          <= 33'd0;
            count        <= 5'd0;
            if (operand_2 == 32'd0) begin
              result <= {operand_1, 32'hFFFF_FFFF};
              state  <= DIV_DONE;
            end else begin
              state  <= DIV_BUSY;
            end
          end else begin
            state <= DIV_IDLE;
          end
        end
        DIV_BUSY: begin
          if (annul) begin
            state <= DIV_IDLE;
          end else begin
            rem      <= step_rem;
            dividend <= final_quot;
            count    <= count + 5'd1;
            if (count == DIV_ITER_LAST) begin
              // Remainder follows the dividend's sign, quotient the XOR of signs.
              result <= {neg_if(step_rem[DATA_BUS-1:0], dividend_neg),
                         neg_if(final_quot, quotient_neg)};
              state  <= DIV_DONE;
            end else begin
              state  <= DIV_BUSY;
            end
          end
        end
        DIV_DONE: begin
          state <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state == DIV_BUSY);
  assign done       = (state == DIV_DONE);
  assign result_div = result;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed cases plus randomized divides
// checked against a plain-arithmetic reference model.
module tb_divider;
  import divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        annul;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        busy;
  logic        done;
  logic [63:0] result_div;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] last_exp = 64'd0;

  divider dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .funct      (funct),
    .operand_1  (operand_1),
    .operand_2  (operand_2),
    .busy       (busy),
    .done       (done),
    .result_div (result_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics via 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (f == FUNCT_DIV) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Issue one divide and check latency, busy length, result and pulse width.
  // With noisy set, start/funct/operands are scrambled while it runs.
  task automatic run_div(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit noisy);
    int lat, nbusy, exp_lat;
    @(negedge clk);
    funct = f; operand_1 = a; operand_2 = b; start = 1'b1;
    @(negedge clk);
    lat = 0; nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) nbusy++;
      if (noisy) begin
        start     = 1'($urandom);
        operand_1 = $urandom;
        operand_2 = $urandom;
        case ($urandom_range(0, 2))
          0:       funct = FUNCT_DIV;
          1:       funct = FUNCT_DIVU;
          default: funct = FUNCT_MULT;
        endcase
      end else begin
        start = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    start = 1'b0;
    exp_lat = (b == 32'd0) ? 0 : 32;
    chk("done_latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(nbusy), 64'(exp_lat));
    chk("result", result_div, exp);
    @(negedge clk);
    chk("done_drop", {63'd0, done}, 64'd0);
    chk("result_hold", result_div, exp);
    last_exp = exp;
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    bit          saw_done;

    rst = 1'b1; start = 1'b0; annul = 1'b0; funct = FUNCT_DIVU;
    operand_1 = 32'd0; operand_2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", result_div, 64'd0);
    rst = 1'b0;

    run_div(FUNCT_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
    run_div(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
    run_div(FUNCT_DIV, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 1'b0);
    run_div(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 1'b0);
    run_div(FUNCT_DIVU, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b0);
    run_div(FUNCT_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);

    // Annul on the 10th busy cycle: back to IDLE, no done, result unchanged.
    @(negedge clk);
    funct = FUNCT_DIV; operand_1 = 32'd9; operand_2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0;
    chk("annul_busy", {63'd0, busy}, 64'd0);
    chk("annul_done", {63'd0, done}, 64'd0);
    chk("annul_result", result_div, last_exp);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("annul_no_done", {63'd0, saw_done}, 64'd0);
    run_div(FUNCT_DIVU, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

    // Start with a non-divide funct is a no-op.
    @(negedge clk);
    funct = FUNCT_MULT; operand_1 = 32'd50; operand_2 = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    repeat (3) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("mult_ignored", {63'd0, saw_done}, 64'd0);
    chk("mult_result", result_div, last_exp);

    // Reset mid-BUSY clears every output on the next cycle.
    @(negedge clk);
    funct = FUNCT_DIV; operand_1 = 32'd1000; operand_2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_result", result_div, 64'd0);
    last_exp = 64'd0;

    // Randomized divides with inputs scrambled during iteration.
    for (int i = 0; i < 40; i++) begin
      f = ($urandom_range(0, 1) == 0) ? FUNCT_DIV : FUNCT_DIVU;
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'h8000_0000;
        default: b = $urandom;
      endcase
      if (i % 10 == 9) a = 32'h8000_0000;
      run_div(f, a, b, model(f, a, b), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
